alu_nbit_seq: RTL and testbench

//  Parametrised successor to the team's 8-bit ALU: WIDTH-bit operands packed in one instruction word,

---
 rtl/alu_nbit_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// WIDTH-bit sequential ALU: single-cycle logic/add/sub/shift, WIDTH-cycle shift-add multiply.
// Define ALU_DIV_EN to add the WIDTH-cycle restoring divider on op 111.
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3+2*WIDTH-1:0] instr,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 Cout,
  output logic                 overflow,
  output logic                 div_zero,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a, w_b;
  assign {w_op, w_a, w_b} = instr;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_y;
  logic               r_cout, r_ovf, r_dz, r_done;

  // multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef ALU_DIV_EN
  logic               r_is_div;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dvsr;
  logic [WIDTH:0]     w_rem_sh, w_rem_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;

  // remainder stays below the divisor, so the W+1-bit difference sign tells restore vs. keep
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_dvsr};
  assign w_ge       = ~w_rem_diff[WIDTH];
  assign w_rem_nxt  = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
`endif

  // single-cycle result path, plus the decision to enter RUN
  logic [2*WIDTH-1:0] w_y;
  logic               w_cout, w_ovf, w_dz, w_multi;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH-1:0] w_shl;

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_shl  = {{WIDTH{1'b0}}, w_a} << w_b[SW-1:0];

  always_comb begin
    w_y     = '0;
    w_cout  = 1'b0;
    w_ovf   = 1'b0;
    w_dz    = 1'b0;
    w_multi = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_y[WIDTH-1:0] = w_sum[WIDTH-1:0];
        w_cout         = w_sum[WIDTH];
        w_ovf          = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_y[WIDTH-1:0] = w_diff[WIDTH-1:0];
        w_cout         = ~w_diff[WIDTH];
        w_ovf          = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND: w_y[WIDTH-1:0] = w_a & w_b;
      OP_OR:  w_y[WIDTH-1:0] = w_a | w_b;
      OP_XOR: w_y[WIDTH-1:0] = w_a ^ w_b;
      OP_SHL: begin
        w_y   = w_shl;
        w_ovf = |w_shl[2*WIDTH-1:WIDTH];
      end
      OP_MUL: w_multi = 1'b1;
      default: begin
`ifdef ALU_DIV_EN
        if (w_b == '0) begin
          w_y   = {w_a, {WIDTH{1'b1}}};
          w_ovf = 1'b1;
          w_dz  = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
`else
        w_ovf = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_y      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`ifdef ALU_DIV_EN
      r_is_div <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_multi) begin
              r_state  <= S_RUN;
              r_cnt    <= CW'(WIDTH);
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, w_a};
              r_mplier <= w_b;
`ifdef ALU_DIV_EN
              r_is_div <= (w_op != OP_MUL);
              r_rem    <= '0;
              r_quo    <= w_a;
              r_dvsr   <= w_b;
`endif
            end else begin
              r_y    <= w_y;
              r_cout <= w_cout;
              r_ovf  <= w_ovf;
              r_dz   <= w_dz;
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt    <= r_cnt - 1'b1;
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef ALU_DIV_EN
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
`endif
          // last iteration: publish the freshly computed value directly
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_cout  <= 1'b0;
            r_dz    <= 1'b0;
`ifdef ALU_DIV_EN
            if (r_is_div) begin
              r_y   <= {w_rem_nxt, w_quo_nxt};
              r_ovf <= 1'b0;
            end else begin
              r_y   <= w_acc_nxt;
              r_ovf <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            end
`else
            r_y   <= w_acc_nxt;
            r_ovf <= |w_acc_nxt[2*WIDTH-1:WIDTH];
`endif
          end
        end
      endcase
    end
  end

  assign Y        = r_y;
  assign Cout     = r_cout;
  assign overflow = r_ovf;
  assign div_zero = r_dz;
  assign busy     = (r_state == S_RUN);
  assign done     = r_done;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq (WIDTH=8): directed table, handshake corner cases, random vs. model.
module tb_alu_nbit_seq;
  localparam int W = 8;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [3+2*W-1:0] instr;
  logic [2*W-1:0] Y;
  logic          Cout, overflow, div_zero, busy, done;

  int checks = 0;
  int errors = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .instr(instr),
    .Y(Y), .Cout(Cout), .overflow(overflow), .div_zero(div_zero),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] y;
    logic        c, o, z;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // reference model from plain integer arithmetic
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t r;
    int ua, ub, sa, sb, t;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r.op = op; r.a = a; r.b = b;
    r.y = '0; r.c = 0; r.o = 0; r.z = 0; r.lat = 0;
    case (op)
      3'd0: begin t = ua + ub; r.y = 16'(t % 256); r.c = (t > 255); r.o = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r.y = 16'((ua - ub + 256) % 256); r.c = (ua >= ub); r.o = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r.y = {8'h00, a & b};
      3'd3: r.y = {8'h00, a | b};
      3'd4: r.y = {8'h00, a ^ b};
      3'd5: begin t = ua * (1 << (ub % 8)); r.y = 16'(t); r.o = (t > 255); end
      3'd6: begin t = ua * ub; r.y = 16'(t); r.o = (t > 255); r.lat = W; end
      default: begin
`ifdef ALU_DIV_EN
        if (ub == 0) begin r.y = {a, 8'hFF}; r.o = 1; r.z = 1; end
        else begin r.y = 16'((ua % ub) * 256 + ua / ub); r.lat = W; end
`else
        r.o = 1;
`endif
      end
    endcase
    return r;
  endfunction

  // issue one op and wait for done; lat = edges after the accepting edge
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clock);
    start = 1'b1;
    instr = {op, a, b};
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clock);
      #1 lat++;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'hFFFF);
  endtask

  task automatic cmp(input string tag, input vec_t e, input int lat);
    chk({tag, "_Y"}, 32'(Y), 32'(e.y));
    chk({tag, "_Cout"}, 32'(Cout), 32'(e.c));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e.o));
    chk({tag, "_dz"}, 32'(div_zero), 32'(e.z));
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
  endtask

  vec_t tbl[$];
  vec_t e;
  int   lat, nb;

  initial begin
    tbl.push_back('{3'd0, 8'hFF, 8'h01, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{3'd0, 8'h7F, 8'h01, 16'h0080, 0, 1, 0, 0});
    tbl.push_back('{3'd1, 8'h05, 8'h07, 16'h00FE, 0, 0, 0, 0});
    tbl.push_back('{3'd1, 8'h80, 8'h01, 16'h007F, 1, 1, 0, 0});
    tbl.push_back('{3'd2, 8'hF0, 8'h3C, 16'h0030, 0, 0, 0, 0});
    tbl.push_back('{3'd3, 8'hF0, 8'h0C, 16'h00FC, 0, 0, 0, 0});
    tbl.push_back('{3'd4, 8'hAA, 8'h55, 16'h00FF, 0, 0, 0, 0});
    tbl.push_back('{3'd5, 8'h81, 8'h03, 16'h0408, 0, 1, 0, 0});
    tbl.push_back('{3'd5, 8'h11, 8'hF9, 16'h0022, 0, 0, 0, 0});
    tbl.push_back('{3'd6, 8'h08, 8'h08, 16'h0040, 0, 0, 0, 8});
    tbl.push_back('{3'd6, 8'hFF, 8'hFF, 16'hFE01, 0, 1, 0, 8});
    tbl.push_back('{3'd6, 8'h00, 8'hFF, 16'h0000, 0, 0, 0, 8});
`ifdef ALU_DIV_EN
    tbl.push_back('{3'd7, 8'h64, 8'h07, 16'h020E, 0, 0, 0, 8});
    tbl.push_back('{3'd7, 8'h64, 8'h00, 16'h64FF, 0, 1, 1, 0});
    tbl.push_back('{3'd7, 8'h05, 8'hFF, 16'h0500, 0, 0, 0, 8});
`else
    tbl.push_back('{3'd7, 8'h64, 8'h07, 16'h0000, 0, 1, 0, 0});
`endif

    reset = 1'b1; start = 1'b0; instr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_Y", 32'(Y), 32'h0);
    chk("rst_flags", {28'h0, Cout, overflow, div_zero, busy}, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clock) reset = 1'b0;

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      cmp($sformatf("tbl%0d", i), tbl[i], lat);
    end

    // busy must stay up for exactly W cycles of a multiply
    @(negedge clock);
    start = 1'b1; instr = {3'd6, 8'h02, 8'h03};
    @(posedge clock);
    #1 start = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      @(posedge clock);
      #1;
    end
    chk("busy_cycles", 32'(nb), 32'(W));
    chk("busy_Y", 32'(Y), 32'h0006);

    // start held high through MUL, ADD accepted on the done cycle
    @(negedge clock);
    start = 1'b1; instr = {3'd6, 8'h03, 8'h05};
    @(posedge clock);
    #1 instr = {3'd0, 8'h01, 8'h01};
    lat = 0;
    while (!done && lat < 50) begin
      if (Y !== 16'h0006) chk("held_Y_stable", 32'(Y), 32'h0006);
      @(posedge clock);
      #1 lat++;
    end
    chk("held_mul_lat", 32'(lat), 32'(W));
    chk("held_mul_Y", 32'(Y), 32'h000F);
    @(posedge clock);
    #1;
    chk("b2b_Y", 32'(Y), 32'h0002);
    chk("b2b_done", 32'(done), 32'h1);
    chk("b2b_busy", 32'(busy), 32'h0);
    start = 1'b0;

    // reset in the 4th RUN cycle aborts the multiply silently
    @(negedge clock);
    start = 1'b1; instr = {3'd6, 8'h09, 8'h09};
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_Y", 32'(Y), 32'h0);
    @(negedge clock) reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clock);
      #1 if (done || busy) nb++;
    end
    chk("abort_no_late_done", 32'(nb), 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ((i % 16) == 0) b = 8'h00;
      e = model(op, a, b);
      do_op(op, a, b, lat);
      cmp($sformatf("rnd%0d_op%0d_%0h_%0h", i, op, a, b), e, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
